// File: rtl/rsa_ctrl_pkg.sv
// Shared constants for the UART-to-RSA command sequencer: FSM state codes,
// host command bytes and the response bytes returned to the host.
package rsa_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_GET_E    = 4'd1;
    localparam state_t S_GET_D    = 4'd2;
    localparam state_t S_GET_N    = 4'd3;
    localparam state_t S_GET_MSG  = 4'd4;
    localparam state_t S_START    = 4'd5;
    localparam state_t S_WAIT_RSA = 4'd6;
    localparam state_t S_SEND     = 4'd7;
    localparam state_t S_HOLD     = 4'd8;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] CMD_DEC = 8'h44;

    localparam logic [7:0] RSP_ACK  = 8'h41;
    localparam logic [7:0] RSP_BADN = 8'h4E;
    localparam logic [7:0] RSP_UNK  = 8'h3F;
    localparam logic [7:0] RSP_TMO  = 8'hEE;

endpackage

// File: rtl/rsa_ctrl_wdog.sv
// Watchdog for the sequencer: reloads on clr, counts down while enabled and
// flags expiry once TIMEOUT_CYC-1 cycles have elapsed since the last reload.
module rsa_ctrl_wdog #(
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/rsa_uart_ctrl.sv
// Byte-framed command sequencer between the UART pair and the RSA core:
// key load, encrypt and decrypt, one response byte per command.
module rsa_uart_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int WIDTH_DEG   = 8,
    parameter int WIDTH_N     = 8,
    parameter int WIDTH_MSG_I = 8,
    parameter int WIDTH_MSG_O = WIDTH_N,
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int E_RST       = 7,
    parameter int D_RST       = 13,
    parameter int N_RST       = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   rsa_start,
    output logic                   rsa_eORd,
    output logic [WIDTH_MSG_I-1:0] rsa_msg,
    output logic [WIDTH_DEG-1:0]   rsa_e,
    output logic [WIDTH_DEG-1:0]   rsa_d,
    output logic [WIDTH_N-1:0]     rsa_n,
    input  logic                   rsa_finish,
    input  logic [WIDTH_MSG_O-1:0] rsa_result,
    output logic                   busy,
    output logic                   overrun
);

    state_t               state;
    logic [WIDTH_DEG-1:0] sh_e;
    logic [WIDTH_DEG-1:0] sh_d;
    logic                 cmd_enc;
    logic [7:0]           rsp;
    logic                 in_get;
    logic                 wd_en;
    logic                 wd_clr;
    logic                 wd_exp;

    assign in_get = (state == S_GET_E) || (state == S_GET_D) ||
                    (state == S_GET_N) || (state == S_GET_MSG);
    assign wd_en  = in_get || (state == S_WAIT_RSA);
    // Held in reload outside watched states, so every state entry starts fresh.
    assign wd_clr = !wd_en || (in_get && rx_valid);
    assign busy   = (state != S_IDLE);

    rsa_ctrl_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            rsa_start <= 1'b0;
            rsa_eORd  <= 1'b0;
            rsa_msg   <= '0;
            rsa_e     <= WIDTH_DEG'(E_RST);
            rsa_d     <= WIDTH_DEG'(D_RST);
            rsa_n     <= WIDTH_N'(N_RST);
            overrun   <= 1'b0;
            sh_e      <= '0;
            sh_d      <= '0;
            cmd_enc   <= 1'b0;
            rsp       <= '0;
        end else begin
            rsa_start <= 1'b0;
            tx_start  <= 1'b0;
            if (rx_valid && ((state == S_START) || (state == S_WAIT_RSA) ||
                             (state == S_SEND) || (state == S_HOLD))) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_KEY: state <= S_GET_E;
                            CMD_ENC, CMD_DEC: begin
                                cmd_enc <= (rx_data == CMD_ENC);
                                state   <= S_GET_MSG;
                            end
                            default: begin
                                rsp   <= RSP_UNK;
                                state <= S_SEND;
                            end
                        endcase
                    end
                end
                S_GET_E: begin
                    if (rx_valid) begin
                        sh_e  <= rx_data[WIDTH_DEG-1:0];
                        state <= S_GET_D;
                    end else if (wd_exp) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_D: begin
                    if (rx_valid) begin
                        sh_d  <= rx_data[WIDTH_DEG-1:0];
                        state <= S_GET_N;
                    end else if (wd_exp) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_N: begin
                    // A modulus below 2 is rejected and the old key set stays live.
                    if (rx_valid) begin
                        if (rx_data[WIDTH_N-1:0] < WIDTH_N'(2)) begin
                            rsp <= RSP_BADN;
                        end else begin
                            rsa_e <= sh_e;
                            rsa_d <= sh_d;
                            rsa_n <= rx_data[WIDTH_N-1:0];
                            rsp   <= RSP_ACK;
                        end
                        state <= S_SEND;
                    end else if (wd_exp) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_MSG: begin
                    if (rx_valid) begin
                        rsa_msg  <= rx_data[WIDTH_MSG_I-1:0];
                        rsa_eORd <= cmd_enc;
                        state    <= S_START;
                    end else if (wd_exp) begin
                        state <= S_IDLE;
                    end
                end
                S_START: begin
                    rsa_start <= 1'b1;
                    state     <= S_WAIT_RSA;
                end
                S_WAIT_RSA: begin
                    if (rsa_finish) begin
                        rsp   <= 8'(rsa_result);
                        state <= S_SEND;
                    end else if (wd_exp) begin
                        rsp   <= RSP_TMO;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= rsp;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_uart_ctrl.sv
// Directed bench for rsa_uart_ctrl with a behavioural RSA core, a key/response
// model and a per-cycle monitor comparing keys and response bytes.
module tb_rsa_uart_ctrl;

    localparam int TO      = 100;
    localparam int RSA_LAT = 4;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rsa_start;
    logic       rsa_eORd;
    logic [7:0] rsa_msg;
    logic [7:0] rsa_e;
    logic [7:0] rsa_d;
    logic [7:0] rsa_n;
    logic       rsa_finish;
    logic [7:0] rsa_result;
    logic       busy;
    logic       overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int n_tx   = 0;
    int n_rs   = 0;
    int m_e    = 7;
    int m_d    = 13;
    int m_n    = 33;
    int exp_q[$];
    bit rsa_hang = 1'b0;
    bit tx_prev  = 1'b0;

    rsa_uart_ctrl #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .rsa_start (rsa_start),
        .rsa_eORd  (rsa_eORd),
        .rsa_msg   (rsa_msg),
        .rsa_e     (rsa_e),
        .rsa_d     (rsa_d),
        .rsa_n     (rsa_n),
        .rsa_finish(rsa_finish),
        .rsa_result(rsa_result),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modexp(input int b, input int e, input int n);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int budget, input string nm);
        int start = n_tx;
        int i = 0;
        while (n_tx == start && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, int'(n_tx != start), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_finish(input int budget);
        int i = 0;
        while (!rsa_finish && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("finish_seen", int'(rsa_finish), 1);
    endtask

    task automatic do_key(input logic [7:0] e, input logic [7:0] d, input logic [7:0] n);
        exp_q.push_back((n < 2) ? 8'h4E : 8'h41);
        send_byte(8'h4B);
        send_byte(e);
        send_byte(d);
        send_byte(n);
        if (n >= 2) begin
            m_e = e;
            m_d = d;
            m_n = n;
        end
    endtask

    task automatic do_msg(input logic [7:0] cmd, input logic [7:0] msg, input bit hang, input bit chk_lat);
        int exp_v;
        exp_v = (cmd == 8'h45) ? modexp(msg, m_e, m_n) : modexp(msg, m_d, m_n);
        exp_q.push_back(hang ? 8'hEE : exp_v);
        send_byte(cmd);
        send_byte(msg);
        if (chk_lat) begin
            @(negedge clk);
            chk("rsa_start_early", int'(rsa_start), 0);
            @(negedge clk);
            chk("rsa_start_lat2", int'(rsa_start), 1);
            chk("rsa_eORd", int'(rsa_eORd), (cmd == 8'h45) ? 1 : 0);
            chk("rsa_msg", int'(rsa_msg), int'(msg));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_rsa_start"}, int'(rsa_start), 0);
        chk({tag, "_rsa_eORd"}, int'(rsa_eORd), 0);
        chk({tag, "_rsa_msg"}, int'(rsa_msg), 0);
        chk({tag, "_rsa_e"}, int'(rsa_e), 7);
        chk({tag, "_rsa_d"}, int'(rsa_d), 13);
        chk({tag, "_rsa_n"}, int'(rsa_n), 33);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Behavioural RSA core: computes from the operands presented with rsa_start.
    initial begin
        int r;
        rsa_finish = 1'b0;
        rsa_result = '0;
        forever begin
            @(negedge clk);
            if (rsa_start && !rsa_hang && !reset) begin
                r = modexp(int'(rsa_msg), rsa_eORd ? int'(rsa_e) : int'(rsa_d), int'(rsa_n));
                repeat (RSA_LAT) @(posedge clk);
                #1;
                rsa_finish = 1'b1;
                rsa_result = 8'(r);
                @(posedge clk); #1;
                rsa_finish = 1'b0;
            end
        end
    end

    // Monitor: live keys against the model every cycle, each response byte against the queue.
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            chk("key_e", int'(rsa_e), m_e);
            chk("key_d", int'(rsa_d), m_d);
            chk("key_n", int'(rsa_n), m_n);
        end
        if (rsa_start) n_rs++;
        if (tx_start) begin
            n_tx++;
            chk("tx_single_pulse", int'(tx_prev), 0);
            chk("tx_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tx_data", int'(tx_data), e);
            end
        end
        tx_prev = tx_start;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        int r0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_busy  = 1'b0;

        chk("model_enc", modexp(2, 7, 33), 29);
        chk("model_dec", modexp(29, 13, 33), 2);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Encrypt 0x02 with e=7, n=33
        n0 = n_tx;
        do_msg(8'h45, 8'h02, 1'b0, 1'b1);
        wait_finish(20);
        @(negedge clk);
        chk("tx_lat_early", int'(tx_start), 0);
        @(negedge clk);
        chk("tx_lat2", int'(tx_start), 1);
        chk("enc_literal", int'(tx_data), 8'h1D);
        repeat (3) @(negedge clk);
        chk("enc_tx_count", n_tx - n0, 1);

        // Decrypt 0x1D
        do_msg(8'h44, 8'h1D, 1'b0, 1'b1);
        wait_tx(30, "dec_reply");
        chk("dec_literal", int'(tx_data), 8'h02);

        // Key load, then rejected key load
        do_key(8'h03, 8'h07, 8'h21);
        chk("key_commit_e", int'(rsa_e), 3);
        chk("key_commit_d", int'(rsa_d), 7);
        chk("key_commit_n", int'(rsa_n), 33);
        wait_tx(30, "key_ack");
        chk("ack_literal", int'(tx_data), 8'h41);
        do_key(8'h05, 8'h05, 8'h01);
        wait_tx(30, "key_badn");
        chk("badn_literal", int'(tx_data), 8'h4E);
        chk("badn_keep_e", int'(rsa_e), 3);
        do_key(8'h07, 8'h0D, 8'h21);
        wait_tx(30, "key_restore");

        // Unknown command
        exp_q.push_back(8'h3F);
        send_byte(8'h5A);
        wait_tx(30, "unk_reply");
        chk("unk_literal", int'(tx_data), 8'h3F);

        // Partial frame abandoned by the watchdog
        n0 = n_tx;
        send_byte(8'h45);
        repeat (TO - 10) @(negedge clk);
        chk("gap_still_busy", int'(busy), 1);
        repeat (15) @(negedge clk);
        chk("gap_idle", int'(busy), 0);
        chk("gap_no_reply", n_tx - n0, 0);
        do_msg(8'h45, 8'h02, 1'b0, 1'b0);
        wait_tx(30, "post_gap_reply");
        chk("post_gap_literal", int'(tx_data), 8'h1D);

        // Transmitter busy at finish, plus a byte dropped during WAIT_RSA
        tx_busy = 1'b1;
        chk("overrun_before", int'(overrun), 0);
        n0 = n_tx;
        do_msg(8'h45, 8'h02, 1'b0, 1'b0);
        send_byte(8'h55);
        @(negedge clk);
        chk("overrun_set", int'(overrun), 1);
        wait_finish(20);
        repeat (50) @(negedge clk);
        chk("held_no_tx", n_tx - n0, 0);
        chk("held_busy", int'(busy), 1);
        @(posedge clk); #1;
        tx_busy = 1'b0;
        wait_tx(10, "released_reply");
        chk("released_literal", int'(tx_data), 8'h1D);
        chk("overrun_sticky", int'(overrun), 1);

        // RSA core never finishes
        rsa_hang = 1'b1;
        n0 = n_tx;
        do_msg(8'h45, 8'h02, 1'b1, 1'b0);
        repeat (TO - 10) @(negedge clk);
        chk("tmo_not_early", n_tx - n0, 0);
        wait_tx(40, "tmo_reply");
        chk("tmo_literal", int'(tx_data), 8'hEE);

        // Asynchronous reset while waiting on the core
        do_key(8'h05, 8'h0B, 8'h0F);
        wait_tx(30, "key2_ack");
        chk("overrun_still", int'(overrun), 1);
        do_msg(8'h45, 8'h02, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("wait_busy", int'(busy), 1);
        @(posedge clk); #3;
        reset = 1'b1;
        exp_q.delete();
        m_e = 7;
        m_d = 13;
        m_n = 33;
        #1;
        check_reset_vals("async");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n0 = n_tx;
        r0 = n_rs;
        repeat (20) @(negedge clk);
        chk("post_rst_no_tx", n_tx - n0, 0);
        chk("post_rst_no_rs", n_rs - r0, 0);
        chk("post_rst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rsa_uart_ctrl.md
Name: rsa_uart_ctrl

Overview:
Command sequencer between the UART receiver/transmitter pair and the RSA modular-exponentiation core. It parses byte-framed host commands: key load, encrypt and decrypt. It holds the active key set, pulses the RSA start, waits for finish and returns one response byte per command. It replaces the direct rx-ready-to-start and finish-to-tx wiring in the top level.

Parameters:
WIDTH_DEG, 8, width of e/d exponents; must be <= 8
WIDTH_N, 8, width of modulus n; must be <= 8
WIDTH_MSG_I, 8, RSA input message width; must be <= 8
WIDTH_MSG_O, WIDTH_N, RSA output width; must be <= 8
TIMEOUT_CYC, 25_000_000, watchdog limit in clk cycles for inter-byte gaps and RSA completion
E_RST, 7, exponent e after reset
D_RST, 13, exponent d after reset
N_RST, 33, modulus n after reset

Ports:
clk  in  1  single system clock (divided clock domain)
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  response byte, stable from tx_start until the next response
rsa_start  out  1  one-cycle start pulse to the RSA core
rsa_eORd  out  1  1 = use e (encrypt), 0 = use d (decrypt)
rsa_msg  out  WIDTH_MSG_I  operand
rsa_e  out  WIDTH_DEG  active e
rsa_d  out  WIDTH_DEG  active d
rsa_n  out  WIDTH_N  active n
rsa_finish  in  1  one-cycle done pulse from the RSA core
rsa_result  in  WIDTH_MSG_O  result, valid with rsa_finish
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; a byte arrived while not in a GET/IDLE state; cleared only by reset

Behaviour:
- Reset values: state IDLE; tx_start=0, tx_data=0, rsa_start=0, rsa_eORd=0, rsa_msg=0; rsa_e/d/n = E_RST/D_RST/N_RST; busy=0; overrun=0; watchdog=0.
- Commands, first byte of a frame:
  - 0x4B 'K' then bytes e, d, n.
  - 0x45 'E' then msg.
  - 0x44 'D' then msg.
  - Any other first byte gets reply 0x3F '?' and no payload is consumed.
- Payload bytes are truncated to the low bits of the target width.
- States:
  - IDLE: on rx_valid, decode the command and go to GET_E, GET_MSG or SEND('?').
  - GET_E, GET_D, GET_N: each captures one byte into a shadow register.
    - On GET_N completion, if the shadow n < 2, reply 0x4E 'N' and keep the old keys.
    - Otherwise commit e, d and n in the same cycle and reply 0x41 'A'.
  - GET_MSG: captures rsa_msg and sets rsa_eORd from the command, then goes to START.
  - START: rsa_start=1 for exactly one cycle, then WAIT_RSA.
  - WAIT_RSA: on rsa_finish, latch rsa_result zero-extended to 8 bits as the response, then SEND.
  - SEND: hold while tx_busy=1. On the first cycle with tx_busy=0, drive tx_data and tx_start=1 for one cycle, then HOLD.
  - HOLD: one cycle, tx_start=0, so the transmitter can raise busy. Then IDLE.
- rsa_msg, rsa_eORd, rsa_e, rsa_d and rsa_n are stable from START until rsa_finish. Keys never change while busy outside GET_N commit.
- Latency:
  - Last payload byte to rsa_start: 2 cycles.
  - rsa_finish to tx_start: 2 cycles when tx_busy=0.
- Watchdog: counts in GET_* and WAIT_RSA and resets on every accepted byte or state entry.
  - Reaching TIMEOUT_CYC-1 in GET_*: discard the partial frame and go to IDLE without a reply. Shadow keys are discarded.
  - Reaching TIMEOUT_CYC-1 in WAIT_RSA: reply 0xEE.
- rx_valid in START, WAIT_RSA, SEND or HOLD: the byte is dropped and overrun is set.
- rsa_finish outside WAIT_RSA is ignored.
- rx_valid and a watchdog expiry in the same cycle: the byte wins and the watchdog restarts.
- Asynchronous reset mid-operation: all outputs and keys return to reset values immediately. No tx_start or rsa_start pulse is emitted.

Decomposition:
- Shared package rsa_ctrl_pkg:
  - state enum.
  - command constants CMD_KEY=0x4B, CMD_ENC=0x45, CMD_DEC=0x44.
  - reply constants RSP_ACK=0x41, RSP_BADN=0x4E, RSP_UNK=0x3F, RSP_TMO=0xEE.
- One sub-module, rsa_ctrl_wdog: loadable down-counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYC.
- The FSM and registers stay in rsa_uart_ctrl.

Test Plan:
- Reset, then 'E',0x02, with a behavioural RSA model (e=7, n=33) -> rsa_start 2 cycles after the msg byte with rsa_eORd=1 and rsa_msg=0x02; tx_data=0x1D; exactly one tx_start.
- 'D',0x1D -> rsa_eORd=0, rsa_msg=0x1D; response 0x02.
- 'K',0x03,0x07,0x21 -> reply 0x41; rsa_e=3, rsa_d=7, rsa_n=33 committed in one cycle. Then 'K',0x05,0x05,0x01 -> reply 0x4E and keys unchanged.
- 0x5A -> reply 0x3F. Then 'E' followed by a gap of TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in the bench) -> no reply, busy low, and the next 'E',0x02 still yields 0x1D.
- Hold tx_busy=1 for 50 cycles at finish while pulsing rx_valid during WAIT_RSA -> tx_start waits until busy drops; overrun=1 and stays 1 until reset. RSA model that never finishes -> reply 0xEE after TIMEOUT_CYC.
- Assert reset during WAIT_RSA -> all outputs at reset values; keys back to 7/13/33; no spurious pulses after release.
